decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
// - Decode stage between instruction fetch and the 32x32 register file.
// - Splits each fetched word into register read addresses, driven combinationally into the regfile read ports.
// - Registers opcode, destination, immediate and control alongside the regfile's registered read data.
// - A write-pending scoreboard stalls fetch on read-after-write hazards (no forwarding exists in this pipe).
// PARAMETERS
// - HAZ_DEPTH   3   cycles a writing instr stays pending after issue (EX, MEM, WB before regfile write lands)
// - CNT_W      16   width of stall performance counter
// PORTS
// - clk            in   1   single clock, rising edge
// - reset          in   1   asynchronous, active-high; clears all state
// - instr_in       in  32   fetched instruction
// - in_valid       in   1   instr_in valid
// - in_ready       out  1   decode accepts instr_in this cycle (comb)
// - flush          in   1   sync kill of the instr currently in decode
// - r1_add         out  5   regfile read addr 1 (comb, = instr_in[20:16])
// - r2_add         out  5   regfile read addr 2 (comb, see BEHAVIOUR)
// - ex_valid       out  1   registered: decoded instr valid, aligned with regfile r1_value/r2_value
// - ex_opcode      out  6   registered opcode
// - ex_rd          out  5   registered destination addr
// - ex_imm         out 32   registered sign-extended imm16
// - ex_use_imm     out  1   operand B = ex_imm, not r2_value
// - ex_write_en    out  1   instr writes ex_rd at writeback
// - ex_illegal     out  1   opcode undefined; instr issued as bubble
// - stall_count    out CNT_W  saturating count of hazard-stall cycles
// BEHAVIOUR
// - Format: [31:26] opcode, [25:21] rd, [20:16] rs1, [15:11] rs2, [15:0] imm16.
// - Opcodes: 00 ALU_R (rs1, rs2 -> rd), 01 ALU_I (rs1, imm -> rd), 02 LOAD (rs1 + imm -> rd),
//   03 STORE (rs1 base, data register in rd field, imm; no write), 3F NOP. All others illegal.
// - r2_add = instr_in[25:21] for STORE, else instr_in[15:11]. Sources used: ALU_R rs1+rs2; ALU_I/LOAD rs1; STORE rs1+rd field.
// - Scoreboard: HAZ_DEPTH shift entries {v, rd}, shifting every edge. Entry0 loads {1, rd} when an instr is accepted
//   with write_en=1 and no flush; otherwise entry0 loads {0, x}.
// - hazard = in_valid & (any used source == rd of any valid entry). Register 0 is tracked like any other register.
// - in_ready = ~hazard | flush. Accept = in_valid & in_ready & ~flush.
// - Latency 1: an instr accepted in cycle T has ex_* valid in T+1, with regfile data available the same cycle.
// - A dependent instr issued at T is accepted no earlier than T+HAZ_DEPTH+1.
// - ex_valid = Accept & legal. On a bubble, stall, flush or illegal opcode: ex_valid=0, ex_write_en=0;
//   other ex_* fields hold their values. ex_illegal=1 for 1 cycle on an accepted illegal opcode.
// - stall_count += 1 each cycle in_valid & hazard & ~flush; saturates at all-ones.
// - flush with in_valid in the same cycle: instr dropped, in_ready=1 (fetch advances), no scoreboard entry.
//   Older scoreboard entries are unaffected.
// - Reset, async, including mid-stall: all ex_* = 0, scoreboard cleared, stall_count = 0. in_ready=1 during reset.
// - Simultaneous shift-out of the matching entry and a new request: hazard is evaluated on current entries,
//   so the request is accepted the following cycle.
// STRUCTURE
// - decode_pkg: opcode constants, instruction field bit positions, HAZ_DEPTH default.
// - Sub-module hazard_scoreboard: shift register plus comparators.
//   Inputs: push, push_rd, two source addrs, their use flags. Output: hazard.
// - Top level: field decode, r2_add mux, ex_* output registers, stall counter.
// TESTING
// - Reset mid-stream -> all ex_* = 0, stall_count=0, in_ready=1 while reset=1 and on the first cycle after release.
// - ALU_R rd=5 at T, then ALU_R rs1=5 -> in_ready=0 for T+1..T+3, accepted T+4, stall_count=3.
// - ALU_I rd=7, then STORE with rd field=7 -> stall, because the STORE reads r7 through r2_add.
//   Same case with an intervening ALU_R rd=9 at T+1 -> 2 stall cycles.
// - LOAD imm16=16'hFFFC -> ex_imm=32'hFFFFFFFC, ex_use_imm=1, ex_write_en=1 at T+1; r1_add=rs1 during T.
// - Opcode 6'h2A -> ex_valid=0, ex_illegal=1 for 1 cycle, no scoreboard entry (next instr is not stalled).
// - flush during a hazard stall -> in_ready=1, instr dropped, ex_valid=0.
//   Next non-dependent instr is accepted the following cycle. Force stall_count near max -> saturates at 16'hFFFF.

Source files
------------

// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// Module : decode_pkg
// Brief  : Opcodes, instruction field positions and control decode for decode_stage.
// Rev    : 1.0
// ============================================================================
package decode_pkg;

    localparam int c_HAZ_DEPTH = 3;
    localparam int c_CNT_W     = 16;

    localparam logic [5:0] c_OP_ALU_R = 6'h00;
    localparam logic [5:0] c_OP_ALU_I = 6'h01;
    localparam logic [5:0] c_OP_LOAD  = 6'h02;
    localparam logic [5:0] c_OP_STORE = 6'h03;
    localparam logic [5:0] c_OP_NOP   = 6'h3F;

    localparam int c_OPC_LSB = 26;
    localparam int c_RD_LSB  = 21;
    localparam int c_RS1_LSB = 16;
    localparam int c_RS2_LSB = 11;
    localparam int c_IMM_LSB = 0;

    typedef struct packed {
        logic legal;
        logic write_en;
        logic use_rs1;
        logic use_src2;
        logic use_imm;
        logic src2_is_rd;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
        ctrl_t c;
        c = '0;
        case (opcode)
            c_OP_ALU_R: begin
                c.legal = 1'b1; c.write_en = 1'b1; c.use_rs1 = 1'b1; c.use_src2 = 1'b1;
            end
            c_OP_ALU_I, c_OP_LOAD: begin
                c.legal = 1'b1; c.write_en = 1'b1; c.use_rs1 = 1'b1; c.use_imm = 1'b1;
            end
            // Store data comes from the rd field, read through the second port.
            c_OP_STORE: begin
                c.legal = 1'b1; c.use_rs1 = 1'b1; c.use_src2 = 1'b1;
                c.use_imm = 1'b1; c.src2_is_rd = 1'b1;
            end
            c_OP_NOP: c.legal = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module : hazard_scoreboard
// Brief  : Write-pending shift register; flags reads of registers still in flight.
// Rev    : 1.0
// ============================================================================
module hazard_scoreboard
    import decode_pkg::*;
#(
    parameter int HAZ_DEPTH = c_HAZ_DEPTH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [4:0] push_rd,
    input  logic [4:0] src1,
    input  logic [4:0] src2,
    input  logic       use1,
    input  logic       use2,
    output logic       hazard
);

    logic                 r_valid [HAZ_DEPTH];
    logic [4:0]           r_rd    [HAZ_DEPTH];
    logic [HAZ_DEPTH-1:0] w_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < HAZ_DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_rd[i]    <= '0;
            end
        end else begin
            r_valid[0] <= push;
            r_rd[0]    <= push_rd;
            for (int i = 1; i < HAZ_DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_rd[i]    <= r_rd[i-1];
            end
        end
    end

    // Compare against current entries only; an entry leaving this edge still blocks.
    for (genvar g = 0; g < HAZ_DEPTH; g++) begin : g_cmp
        assign w_hit[g] = r_valid[g] &
                          ((use1 & (r_rd[g] == src1)) | (use2 & (r_rd[g] == src2)));
    end

    assign hazard = |w_hit;

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module : decode_stage
// Brief  : Field decode, regfile address drive, ex_* registers, RAW stall and stall counter.
// Rev    : 1.0
// ============================================================================
module decode_stage
    import decode_pkg::*;
#(
    parameter int HAZ_DEPTH = c_HAZ_DEPTH,
    parameter int CNT_W     = c_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [4:0]       r1_add,
    output logic [4:0]       r2_add,
    output logic             ex_valid,
    output logic [5:0]       ex_opcode,
    output logic [4:0]       ex_rd,
    output logic [31:0]      ex_imm,
    output logic             ex_use_imm,
    output logic             ex_write_en,
    output logic             ex_illegal,
    output logic [CNT_W-1:0] stall_count
);

    logic [5:0]       w_opcode;
    logic [4:0]       w_rd;
    logic [4:0]       w_rs1;
    logic [4:0]       w_rs2;
    logic [15:0]      w_imm16;
    ctrl_t            w_ctrl;
    logic             w_sb_hit;
    logic             w_hazard;
    logic             w_accept;
    logic             w_stall_cycle;

    logic             r_ex_valid;
    logic [5:0]       r_ex_opcode;
    logic [4:0]       r_ex_rd;
    logic [31:0]      r_ex_imm;
    logic             r_ex_use_imm;
    logic             r_ex_write_en;
    logic             r_ex_illegal;
    logic [CNT_W-1:0] r_stall_count;

    assign w_opcode = instr_in[c_OPC_LSB +: 6];
    assign w_rd     = instr_in[c_RD_LSB  +: 5];
    assign w_rs1    = instr_in[c_RS1_LSB +: 5];
    assign w_rs2    = instr_in[c_RS2_LSB +: 5];
    assign w_imm16  = instr_in[c_IMM_LSB +: 16];
    assign w_ctrl   = decode_ctrl(w_opcode);

    assign r1_add = w_rs1;
    assign r2_add = w_ctrl.src2_is_rd ? w_rd : w_rs2;

    hazard_scoreboard #(
        .HAZ_DEPTH (HAZ_DEPTH)
    ) u_scoreboard (
        .clk     (clk),
        .reset   (reset),
        .push    (w_accept & w_ctrl.write_en),
        .push_rd (w_rd),
        .src1    (r1_add),
        .src2    (r2_add),
        .use1    (w_ctrl.use_rs1),
        .use2    (w_ctrl.use_src2),
        .hazard  (w_sb_hit)
    );

    // Flush overrides a stall so fetch can advance past the killed instruction.
    assign w_hazard      = in_valid & w_sb_hit;
    assign in_ready      = ~w_hazard | flush;
    assign w_accept      = in_valid & in_ready & ~flush;
    assign w_stall_cycle = w_hazard & ~flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex_valid    <= 1'b0;
            r_ex_opcode   <= '0;
            r_ex_rd       <= '0;
            r_ex_imm      <= '0;
            r_ex_use_imm  <= 1'b0;
            r_ex_write_en <= 1'b0;
            r_ex_illegal  <= 1'b0;
        end else begin
            r_ex_valid    <= w_accept & w_ctrl.legal;
            r_ex_write_en <= w_accept & w_ctrl.write_en;
            r_ex_illegal  <= w_accept & ~w_ctrl.legal;
            if (w_accept & w_ctrl.legal) begin
                r_ex_opcode  <= w_opcode;
                r_ex_rd      <= w_rd;
                r_ex_imm     <= sext16(w_imm16);
                r_ex_use_imm <= w_ctrl.use_imm;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (w_stall_cycle && (r_stall_count != {CNT_W{1'b1}})) begin
            r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

    assign ex_valid    = r_ex_valid;
    assign ex_opcode   = r_ex_opcode;
    assign ex_rd       = r_ex_rd;
    assign ex_imm      = r_ex_imm;
    assign ex_use_imm  = r_ex_use_imm;
    assign ex_write_en = r_ex_write_en;
    assign ex_illegal  = r_ex_illegal;
    assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_decode_stage
// Brief  : Directed and random checks of decode_stage against a cycle-count hazard model.
// Rev    : 1.0
// ============================================================================
module tb_decode_stage;

    localparam int HAZ_DEPTH = 3;
    localparam int CNT_W     = 16;
    localparam int SMALL_W   = 4;

    localparam logic [5:0] OP_R = 6'h00;
    localparam logic [5:0] OP_I = 6'h01;
    localparam logic [5:0] OP_L = 6'h02;
    localparam logic [5:0] OP_S = 6'h03;
    localparam logic [5:0] OP_N = 6'h3F;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instr_in = '0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;

    logic             in_ready, ex_valid, ex_use_imm, ex_write_en, ex_illegal;
    logic [4:0]       r1_add, r2_add, ex_rd;
    logic [5:0]       ex_opcode;
    logic [31:0]      ex_imm;
    logic [CNT_W-1:0] stall_count;

    logic               s_in_ready, s_ex_valid, s_ex_use_imm, s_ex_write_en, s_ex_illegal;
    logic [4:0]         s_r1_add, s_r2_add, s_ex_rd;
    logic [5:0]         s_ex_opcode;
    logic [31:0]        s_ex_imm;
    logic [SMALL_W-1:0] s_stall_count;

    decode_stage #(.HAZ_DEPTH(HAZ_DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .instr_in(instr_in), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .r1_add(r1_add), .r2_add(r2_add),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_rd(ex_rd), .ex_imm(ex_imm),
        .ex_use_imm(ex_use_imm), .ex_write_en(ex_write_en), .ex_illegal(ex_illegal),
        .stall_count(stall_count)
    );

    // Narrow-counter copy to reach saturation in a few cycles.
    decode_stage #(.HAZ_DEPTH(HAZ_DEPTH), .CNT_W(SMALL_W)) dut_small (
        .clk(clk), .reset(reset), .instr_in(instr_in), .in_valid(in_valid),
        .in_ready(s_in_ready), .flush(flush), .r1_add(s_r1_add), .r2_add(s_r2_add),
        .ex_valid(s_ex_valid), .ex_opcode(s_ex_opcode), .ex_rd(s_ex_rd), .ex_imm(s_ex_imm),
        .ex_use_imm(s_ex_use_imm), .ex_write_en(s_ex_write_en), .ex_illegal(s_ex_illegal),
        .stall_count(s_stall_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: cycle at which each register's pending write was issued.
    int          cyc = 0;
    int          wr_cycle [32];
    int          exp_stall;
    bit          e_valid, e_we, e_ill, e_use_imm;
    logic [5:0]  e_op;
    logic [4:0]  e_rd;
    logic [31:0] e_imm;
    bit          p_ready;
    logic [4:0]  p_r1, p_r2;

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [15:0] low);
        return {op, rd, rs1, low};
    endfunction

    function automatic logic [15:0] rr(input logic [4:0] rs2);
        return {rs2, 11'd0};
    endfunction

    function automatic int sat(input int v, input int w);
        int top;
        top = (1 << w) - 1;
        return (v > top) ? top : v;
    endfunction

    function automatic bit m_recent(input logic [4:0] r);
        return (cyc - wr_cycle[r]) <= HAZ_DEPTH;
    endfunction

    function automatic bit m_hazard(input logic [31:0] ins, input bit v);
        logic [5:0] op;
        logic [4:0] s2;
        bit u1, u2;
        op = ins[31:26];
        u1 = (op <= 6'h03);
        u2 = (op == OP_R) || (op == OP_S);
        s2 = (op == OP_S) ? ins[25:21] : ins[15:11];
        return v && ((u1 && m_recent(ins[20:16])) || (u2 && m_recent(s2)));
    endfunction

    task automatic model_reset;
        for (int r = 0; r < 32; r++) wr_cycle[r] = -1000;
        exp_stall = 0;
        e_valid = 0; e_we = 0; e_ill = 0; e_use_imm = 0;
        e_op = '0; e_rd = '0; e_imm = '0;
    endtask

    task automatic apply(input logic [31:0] ins, input bit v, input bit f);
        instr_in = ins;
        in_valid = v;
        flush    = f;
        p_r1     = ins[20:16];
        p_r2     = (ins[31:26] == OP_S) ? ins[25:21] : ins[15:11];
        p_ready  = !m_hazard(ins, v) || f;
    endtask

    task automatic tick;
        logic [5:0] op;
        bit legal, wen, hz, acc;
        @(posedge clk);
        op    = instr_in[31:26];
        legal = (op <= 6'h03) || (op == OP_N);
        wen   = (op <= 6'h02);
        hz    = m_hazard(instr_in, in_valid);
        acc   = in_valid && !hz && !flush;
        if (in_valid && hz && !flush) exp_stall++;
        e_valid = acc && legal;
        e_we    = acc && wen;
        e_ill   = acc && !legal;
        if (acc && legal) begin
            e_op      = op;
            e_rd      = instr_in[25:21];
            e_imm     = {{16{instr_in[15]}}, instr_in[15:0]};
            e_use_imm = (op == OP_I) || (op == OP_L) || (op == OP_S);
        end
        if (acc && wen) wr_cycle[instr_in[25:21]] = cyc;
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            apply('0, 1'b0, 1'b0);
            tick();
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        model_reset();
        apply(mk(OP_R, 5'd1, 5'd2, rr(5'd3)), 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({ex_valid, ex_opcode, ex_rd, ex_imm, ex_use_imm, ex_write_en, ex_illegal} !== '0) begin
            n_errors++; $display("FAIL reset_ex got=%0h exp=0", {ex_valid, ex_opcode, ex_rd, ex_imm});
        end
        n_checks++;
        if (stall_count !== '0 || in_ready !== 1'b1) begin
            n_errors++; $display("FAIL reset_cnt_ready got cnt=%0h rdy=%0b exp cnt=0 rdy=1", stall_count, in_ready);
        end
        reset = 1'b0;
        #2;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++; $display("FAIL reset_release_ready got=%0b exp=1", in_ready);
        end
        tick();
    endtask

    task automatic test_raw_alu;
        int base;
        idle(4);
        base = exp_stall;
        apply(mk(OP_R, 5'd5, 5'd1, rr(5'd2)), 1'b1, 1'b0);
        tick();
        for (int k = 1; k <= 4; k++) begin
            apply(mk(OP_R, 5'd8, 5'd5, rr(5'd2)), 1'b1, 1'b0);
            #2;
            n_checks++;
            if (in_ready !== (k == 4)) begin
                n_errors++; $display("FAIL raw_ready T+%0d got=%0b exp=%0b", k, in_ready, (k == 4));
            end
            tick();
        end
        n_checks++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd8) begin
            n_errors++; $display("FAIL raw_issue got valid=%0b rd=%0d exp valid=1 rd=8", ex_valid, ex_rd);
        end
        n_checks++;
        if (stall_count !== CNT_W'(base + 3)) begin
            n_errors++; $display("FAIL raw_stall_count got=%0d exp=%0d", stall_count, base + 3);
        end
    endtask

    task automatic store_wait(input string name, input int exp_n);
        int  n;
        bit  done;
        n = 0;
        done = 0;
        for (int k = 0; k < 10 && !done; k++) begin
            apply(mk(OP_S, 5'd7, 5'd2, 16'h0004), 1'b1, 1'b0);
            #2;
            if (k == 0) begin
                n_checks++;
                if (r2_add !== 5'd7) begin
                    n_errors++; $display("FAIL %s_r2_add got=%0d exp=7", name, r2_add);
                end
            end
            done = in_ready;
            if (!done) n++;
            tick();
        end
        n_checks++;
        if (n !== exp_n) begin
            n_errors++; $display("FAIL %s_stalls got=%0d exp=%0d", name, n, exp_n);
        end
    endtask

    task automatic test_store_hazard;
        idle(4);
        apply(mk(OP_I, 5'd7, 5'd1, 16'h0010), 1'b1, 1'b0);
        tick();
        store_wait("store", 3);
        idle(4);
        apply(mk(OP_I, 5'd7, 5'd1, 16'h0010), 1'b1, 1'b0);
        tick();
        apply(mk(OP_R, 5'd9, 5'd1, rr(5'd2)), 1'b1, 1'b0);
        tick();
        store_wait("store_gap", 2);
    endtask

    task automatic test_load_imm;
        idle(4);
        apply(mk(OP_L, 5'd10, 5'd12, 16'hFFFC), 1'b1, 1'b0);
        #2;
        n_checks++;
        if (r1_add !== 5'd12) begin
            n_errors++; $display("FAIL load_r1_add got=%0d exp=12", r1_add);
        end
        tick();
        n_checks++;
        if (ex_imm !== 32'hFFFFFFFC) begin
            n_errors++; $display("FAIL load_imm got=%0h exp=fffffffc", ex_imm);
        end
        n_checks++;
        if ({ex_valid, ex_use_imm, ex_write_en} !== 3'b111) begin
            n_errors++; $display("FAIL load_ctrl got=%b exp=111", {ex_valid, ex_use_imm, ex_write_en});
        end
    endtask

    task automatic test_illegal;
        idle(4);
        apply(mk(6'h2A, 5'd3, 5'd4, rr(5'd5)), 1'b1, 1'b0);
        tick();
        n_checks++;
        if (ex_valid !== 1'b0 || ex_illegal !== 1'b1 || ex_write_en !== 1'b0) begin
            n_errors++; $display("FAIL illegal_flag got v=%0b ill=%0b we=%0b exp v=0 ill=1 we=0",
                                 ex_valid, ex_illegal, ex_write_en);
        end
        apply(mk(OP_R, 5'd11, 5'd3, rr(5'd3)), 1'b1, 1'b0);
        #2;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++; $display("FAIL illegal_no_entry got ready=%0b exp=1", in_ready);
        end
        tick();
        n_checks++;
        if (ex_illegal !== 1'b0 || ex_valid !== 1'b1) begin
            n_errors++; $display("FAIL illegal_pulse got ill=%0b v=%0b exp ill=0 v=1", ex_illegal, ex_valid);
        end
    endtask

    task automatic test_flush;
        idle(4);
        apply(mk(OP_R, 5'd4, 5'd1, rr(5'd2)), 1'b1, 1'b0);
        tick();
        apply(mk(OP_R, 5'd12, 5'd4, rr(5'd2)), 1'b1, 1'b0);
        #2;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_errors++; $display("FAIL flush_prestall got ready=%0b exp=0", in_ready);
        end
        tick();
        apply(mk(OP_R, 5'd12, 5'd4, rr(5'd2)), 1'b1, 1'b1);
        #2;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++; $display("FAIL flush_ready got=%0b exp=1", in_ready);
        end
        tick();
        n_checks++;
        if (ex_valid !== 1'b0 || ex_write_en !== 1'b0) begin
            n_errors++; $display("FAIL flush_drop got v=%0b we=%0b exp 0 0", ex_valid, ex_write_en);
        end
        apply(mk(OP_R, 5'd13, 5'd10, rr(5'd11)), 1'b1, 1'b0);
        #2;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++; $display("FAIL flush_next_ready got=%0b exp=1", in_ready);
        end
        tick();
        n_checks++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd13) begin
            n_errors++; $display("FAIL flush_next_issue got v=%0b rd=%0d exp v=1 rd=13", ex_valid, ex_rd);
        end
    endtask

    task automatic test_reset_mid_stall;
        idle(4);
        apply(mk(OP_R, 5'd6, 5'd1, rr(5'd2)), 1'b1, 1'b0);
        tick();
        apply(mk(OP_R, 5'd14, 5'd6, rr(5'd2)), 1'b1, 1'b0);
        tick();
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({ex_valid, ex_opcode, ex_rd, ex_imm, ex_use_imm, ex_write_en, ex_illegal} !== '0 ||
            stall_count !== '0) begin
            n_errors++; $display("FAIL midreset_clear got rd=%0d cnt=%0d exp 0 0", ex_rd, stall_count);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++; $display("FAIL midreset_ready got=%0b exp=1", in_ready);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        apply(mk(OP_R, 5'd14, 5'd6, rr(5'd2)), 1'b1, 1'b0);
        #2;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++; $display("FAIL midreset_release_ready got=%0b exp=1", in_ready);
        end
        tick();
        n_checks++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd14) begin
            n_errors++; $display("FAIL midreset_issue got v=%0b rd=%0d exp v=1 rd=14", ex_valid, ex_rd);
        end
    endtask

    task automatic test_saturate;
        idle(4);
        for (int p = 0; p < 6; p++) begin
            apply(mk(OP_R, 5'(p + 1), 5'd0, rr(5'd0)), 1'b1, 1'b0);
            tick();
            repeat (4) begin
                apply(mk(OP_R, 5'd20, 5'(p + 1), rr(5'd21)), 1'b1, 1'b0);
                tick();
            end
        end
        n_checks++;
        if (s_stall_count !== 4'hF) begin
            n_errors++; $display("FAIL sat_small got=%0h exp=f", s_stall_count);
        end
        n_checks++;
        if (stall_count !== CNT_W'(sat(exp_stall, CNT_W))) begin
            n_errors++; $display("FAIL sat_main got=%0d exp=%0d", stall_count, sat(exp_stall, CNT_W));
        end
    endtask

    task automatic test_random;
        logic [5:0] op;
        for (int k = 0; k < 400; k++) begin
            case ($urandom % 7)
                0: op = OP_R;
                1: op = OP_I;
                2: op = OP_L;
                3: op = OP_S;
                4: op = OP_N;
                default: op = 6'($urandom);
            endcase
            apply(mk(op, 5'($urandom % 4), 5'($urandom % 4), {5'($urandom % 4), 11'($urandom)}),
                  ($urandom % 4) != 0, ($urandom % 10) == 0);
            #2;
            n_checks++;
            if ({in_ready, r1_add, r2_add} !== {p_ready, p_r1, p_r2}) begin
                n_errors++; $display("FAIL rnd_comb cyc=%0d got=%0h exp=%0h", cyc,
                                     {in_ready, r1_add, r2_add}, {p_ready, p_r1, p_r2});
            end
            tick();
            n_checks++;
            if ({ex_valid, ex_opcode, ex_rd, ex_imm, ex_use_imm, ex_write_en, ex_illegal} !==
                {e_valid, e_op, e_rd, e_imm, e_use_imm, e_we, e_ill}) begin
                n_errors++; $display("FAIL rnd_ex cyc=%0d got=%0h exp=%0h", cyc,
                    {ex_valid, ex_opcode, ex_rd, ex_imm, ex_use_imm, ex_write_en, ex_illegal},
                    {e_valid, e_op, e_rd, e_imm, e_use_imm, e_we, e_ill});
            end
            n_checks++;
            if (stall_count !== CNT_W'(sat(exp_stall, CNT_W)) ||
                s_stall_count !== SMALL_W'(sat(exp_stall, SMALL_W))) begin
                n_errors++; $display("FAIL rnd_stall cyc=%0d got=%0d/%0d exp=%0d", cyc,
                                     stall_count, s_stall_count, exp_stall);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_raw_alu();
        test_store_hazard();
        test_load_imm();
        test_illegal();
        test_flush();
        test_saturate();
        test_reset_mid_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
